// File: rtl/draw_sprite_anim_if.sv
// VGA timing and colour bundle passed between chained drawing stages.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite_anim.sv
// Animated, mirrorable, colour-keyed sprite overlay for the vga_if pipeline.
// Position, enable, mirror and animation step update only at the start of vertical blanking.
module draw_sprite_anim #(
   parameter int          SPRITE_W    = 64,
   parameter int          SPRITE_H    = 64,
   parameter int          FRAMES      = 4,
   parameter int          FRAME_DIV   = 8,
   parameter int          ROM_LATENCY = 1,
   parameter logic [11:0] TRANSPARENT = 12'hF0F,
   localparam int         XW          = $clog2(SPRITE_W),
   localparam int         YW          = $clog2(SPRITE_H),
   localparam int         FW          = $clog2(FRAMES)
) (
   input  logic               clk60MHz,
   input  logic               rst,
   input  logic [10:0]        xpos,
   input  logic [10:0]        ypos,
   input  logic               mirror,
   input  logic               enable,
   input  logic               anim_run,
   input  logic [11:0]        rgb_pixel,
   output logic [FW+YW+XW-1:0] pixel_addr,
   output logic [FW-1:0]      frame_idx,
   vga_if.in                  in,
   vga_if.out                 out
);

   localparam logic [XW-1:0] DX_MAX = XW'(SPRITE_W - 1);
   localparam logic [7:0]    DIV_MAX = 8'(FRAME_DIV - 1);

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [11:0] rgb;
      logic        hit;
   } beat_t;

   logic          vblnk_prev;
   logic          vb_rise;
   logic [10:0]   ax;
   logic [10:0]   ay;
   logic          am;
   logic          aen;
   logic [7:0]    div_cnt;
   logic          hit;
   logic [11:0]   h_ext;
   logic [11:0]   v_ext;
   logic [XW-1:0] dx_raw;
   logic [XW-1:0] dx;
   logic [YW-1:0] dy;
   beat_t         head;
   beat_t         tail;
   beat_t         pipe [ROM_LATENCY];

   assign vb_rise = in.vblnk && !vblnk_prev;
   assign tail    = pipe[ROM_LATENCY-1];

   // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      // 12-bit compares let a sprite near count 2047 clip instead of wrapping to column 0.
      h_ext  = {1'b0, in.hcount};
      v_ext  = {1'b0, in.vcount};
      hit    = aen
               && (h_ext >= {1'b0, ax}) && (h_ext < {1'b0, ax} + 12'(SPRITE_W))
               && (v_ext >= {1'b0, ay}) && (v_ext < {1'b0, ay} + 12'(SPRITE_H));
      dx_raw = XW'(in.hcount - ax);
      dx     = am ? DX_MAX - dx_raw : dx_raw;
      dy     = YW'(in.vcount - ay);
      pixel_addr = rst ? '0 : {frame_idx, dy, dx};

      head.vcount = in.vcount;
      head.vsync  = in.vsync;
      head.vblnk  = in.vblnk;
      head.hcount = in.hcount;
      head.hsync  = in.hsync;
      head.hblnk  = in.hblnk;
      head.rgb    = in.rgb;
      head.hit    = hit;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         ax         <= '0;
         ay         <= '0;
         am         <= 1'b0;
         aen        <= 1'b0;
         div_cnt    <= '0;
         frame_idx  <= '0;
      end else begin
         vblnk_prev <= in.vblnk;
         if (vb_rise) begin
            ax  <= xpos;
            ay  <= ypos;
            am  <= mirror;
            aen <= enable;
            if (anim_run) begin
               if (div_cnt == DIV_MAX) begin
                  div_cnt   <= '0;
                  frame_idx <= frame_idx + FW'(1);
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
         end
      end
   end

   // NOTE: the delay line is reset on purpose so a mid-frame reset discards in-flight pixels.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         for (int i = 0; i < ROM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= head;
         for (int i = 1; i < ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The delayed beat meets the ROM word addressed ROM_LATENCY clocks earlier.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         out.vcount <= '0;
         out.vsync  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.hcount <= '0;
         out.hsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.vcount <= tail.vcount;
         out.vsync  <= tail.vsync;
         out.vblnk  <= tail.vblnk;
         out.hcount <= tail.hcount;
         out.hsync  <= tail.hsync;
         out.hblnk  <= tail.hblnk;
         out.rgb    <= (!tail.vblnk && !tail.hblnk && tail.hit && (rgb_pixel != TRANSPARENT))
                       ? rgb_pixel : tail.rgb;
      end
   end

endmodule

// File: doc/draw_sprite_anim.md
# draw_sprite_anim

Parametrised, animated sprite overlay stage for the VGA pipeline. Drives a sprite-ROM address from the incoming beam position and a runtime sprite position, then substitutes the ROM pixel into the passing `vga_if` stream. The block supports multi-frame animation, horizontal mirroring and colour-key transparency. Position and frame changes are latched only at the start of vertical blanking, so no frame ever tears. It chains between any two `vga_if` drawing stages and replaces the fixed-position single-image drawers.

## Interface
Parameters:
- `SPRITE_W`, 64: sprite width in pixels; power of two, 8..256. `XW = $clog2(SPRITE_W)`.
- `SPRITE_H`, 64: sprite height in pixels; power of two, 8..256. `YW = $clog2(SPRITE_H)`.
- `FRAMES`, 4: animation frames stored consecutively in ROM; power of two, 2..16. `FW = $clog2(FRAMES)`.
- `FRAME_DIV`, 8: number of video frames per animation step; 1..255.
- `ROM_LATENCY`, 1: ROM read latency in clocks, 1..4.
- `TRANSPARENT`, 12'hF0F: colour key. ROM pixels equal to this value are not drawn.

Ports:
- `clk60MHz`, in, 1: pixel clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `xpos`, in, 11: requested left edge of the sprite (hcount units).
- `ypos`, in, 11: requested top edge of the sprite (vcount units).
- `mirror`, in, 1: requests horizontal flip.
- `enable`, in, 1: requests that the sprite be visible.
- `anim_run`, in, 1: when 1, animation advances; when 0, the current frame is held.
- `rgb_pixel`, in, 12: ROM data. Valid `ROM_LATENCY` clocks after `pixel_addr`.
- `pixel_addr`, out, FW+YW+XW: ROM address, `{frame_idx, dy, dx}`.
- `frame_idx`, out, FW: currently displayed animation frame.
- `in`, `vga_if.in`: upstream timing and rgb.
- `out`, `vga_if.out`: downstream timing and rgb.

## Operation
- **Frame-start event.** `vb_rise` is asserted when `in.vblnk == 1` and the registered previous `in.vblnk == 0`.
- **Shadow latch.** On `vb_rise`, the block copies `xpos`, `ypos`, `mirror` and `enable` into the active registers `ax`, `ay`, `am` and `aen`. These registers hold their values at every other time.
- **Animation counter.** On `vb_rise` with `anim_run == 1`:
  - If `div_cnt == FRAME_DIV-1`, `div_cnt` becomes 0 and `frame_idx` becomes `(frame_idx+1) mod FRAMES`.
  - Otherwise `div_cnt` increments by 1.
  - With `anim_run == 0`, both counters hold.
- **Hit test** (input stage, 12-bit unsigned arithmetic so there is no wrap):
  - `hit = aen && hcount >= ax && hcount < ax+SPRITE_W && vcount >= ay && vcount < ay+SPRITE_H`.
  - A sprite extending past the 2047 count is clipped, not wrapped.
- **Address** (combinational from `in.*` and the active registers):
  - `dx = (in.hcount - ax)[XW-1:0]`, replaced by `SPRITE_W-1-dx` when `am == 1`.
  - `dy = (in.vcount - ay)[YW-1:0]`.
  - `pixel_addr` is forced to 0 while `rst == 1`.
- **Delay line.** `hit` and all `in` fields (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb) pass through a `ROM_LATENCY`-deep register delay line.
- **Output stage** (registered):
  - `out.rgb = rgb_pixel` when the delayed `!vblnk && !hblnk && hit && rgb_pixel != TRANSPARENT`; otherwise `out.rgb` is the delayed `rgb`.
  - All other `out` fields are the delayed input fields.
- **Reset.**
  - All `out` fields, delay stages, `ax`, `ay`, `am`, `aen`, `div_cnt` and `frame_idx` are 0.
  - `rst` overrides a coincident `vb_rise`.
  - A reset in mid-frame discards the in-flight pipeline. After release, the sprite stays invisible until the next `vb_rise` latches `enable`.

## Timing
- **Latency.** Every `out` field lags the corresponding `in` field by exactly `ROM_LATENCY+1` clocks. There is no backpressure and no bubbles.
- **Address-to-data alignment.** The `pixel_addr` issued in cycle t pairs with the `rgb_pixel` arriving in cycle t+`ROM_LATENCY`. That data is registered to `out` in cycle t+`ROM_LATENCY`+1.
- **Input changes mid-frame.** Changes to `xpos`, `ypos`, `mirror` or `enable` mid-frame have no effect until the next `vb_rise`. The new values apply from the first active line of the following frame.
- **Frame index.** `frame_idx` changes only on the clock after `vb_rise`. It is therefore constant across every visible frame.
- **Divider setting.** With `FRAME_DIV == 1`, the frame advances on every `vb_rise`.
- **Held vblnk.** A `vblnk` held high for many cycles produces exactly one `vb_rise`.

## Test plan
- **Reset and latency.** Sweep `ROM_LATENCY` = 1 and 3 with a full 800x600 timing stream. Required response:
  - All `out` fields are 0 during `rst`.
  - After release, `out` matches `in` delayed by 2 and 4 clocks respectively.
  - `out.rgb` equals the background everywhere while `enable` is 0.
- **Placement and address.** `xpos=100`, `ypos=50`, `enable=1`, ROM model returning `addr[11:0]`. Required response:
  - Pixel (100,50) outputs the value for address `{frame,0,0}`.
  - Pixel (163,113) outputs the value for `{frame,63,63}`.
  - Pixels (99,50) and (164,50) output the background.
- **Mirror and transparency.** `mirror=1`. Required response:
  - Pixel (100,50) reads address dx=63.
  - A ROM word of 12'hF0F at any hit pixel passes the background through.
  - Neighbouring non-key pixels are drawn.
- **Shadow latch.** Change `xpos` from 100 to 300 on line 200. Required response:
  - The current frame still draws at 100.
  - The next frame draws at 300.
  - `enable` deasserted mid-frame takes effect only at the next frame.
- **Animation.** `FRAME_DIV=2`, `FRAMES=4`, `anim_run=1` for 9 `vblnk` rises. Required response:
  - `frame_idx` sequence is 0,0,1,1,2,2,3,3,0.
  - Dropping `anim_run` holds both `frame_idx` and `div_cnt`.
  - A reset asserted mid-count returns both to 0.
- **Edge clipping.** `xpos=2020`. Required response:
  - Columns 2020..2047 draw.
  - Columns 0..35 do not draw (no wrap).
  - `pixel_addr` dx at hcount 2047 is 27.
